// File: rtl/set_counter_nc.sv
// ---------------------------------------------------------------------------
// set_counter_nc
//
// Pipelined lattice point-set counter. After a start request the block scans
// every point (x,y) of a GRID x GRID lattice (coordinates 1..GRID), one point
// per clock. For each point it tests NCIRC circles in parallel and counts the
// points that satisfy the membership rule selected by 'mode'.
//
// Pipeline:
//   scan counter (x,y) -> stage 1 register (per-circle inside bits)
//                      -> stage 2 accumulate (candidate += hit)
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   en        start request, sampled only in IDLE
//   central   NCIRC packed {X,Y} centres, circle 0 in the most significant field
//   radius    NCIRC packed radii, circle 0 in the most significant field
//   mode      membership rule (0: in circle 0, 1: in all, 2: odd count,
//             3: exactly k circles), latched at start
//   k         target count for mode 3, latched at start
//   busy      high from the start edge through the DONE cycle
//   valid     one-cycle pulse in DONE; candidate is final
//   candidate number of qualifying points, held until next start or reset
// ---------------------------------------------------------------------------
module set_counter_nc #(
    parameter int GRID  = 8,
    parameter int CW    = 4,
    parameter int NCIRC = 3,
    parameter int KW    = $clog2(NCIRC + 1),
    parameter int CNTW  = $clog2(GRID * GRID + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [2*CW*NCIRC-1:0]   central,
    input  logic [CW*NCIRC-1:0]     radius,
    input  logic [1:0]              mode,
    input  logic [KW-1:0]           k,
    output logic                    busy,
    output logic                    valid,
    output logic [CNTW-1:0]         candidate
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CW-1:0] GRID_C = CW'(GRID);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    // -----------------------------------------------------------------------
    // Arithmetic helpers
    // -----------------------------------------------------------------------
    function automatic logic [CW-1:0] abs_diff(input logic [CW-1:0] a,
                                               input logic [CW-1:0] b);
        logic [CW-1:0] d;
        if (a >= b) begin
            d = a - b;
        end else begin
            d = b - a;
        end
        return d;
    endfunction

    // Full-width square: operand is widened first so no product bits are lost.
    function automatic logic [2*CW-1:0] square(input logic [CW-1:0] v);
        logic [2*CW-1:0] w;
        w = {{CW{1'b0}}, v};
        return w * w;
    endfunction

    function automatic logic [KW-1:0] popcount(input logic [NCIRC-1:0] bits);
        logic [KW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < NCIRC; i++) begin
            cnt = cnt + KW'(bits[i]);
        end
        return cnt;
    endfunction

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    state_t                  state_r;
    state_t                  state_s;
    logic [2*CW*NCIRC-1:0]   central_r;
    logic [CW*NCIRC-1:0]     radius_r;
    logic [1:0]              mode_r;
    logic [KW-1:0]           k_r;
    logic [CW-1:0]           x_r;
    logic [CW-1:0]           y_r;
    logic [NCIRC-1:0]        s1_in_r;
    logic                    s1_vld_r;
    logic [CNTW-1:0]         candidate_r;

    logic                    start_s;
    logic                    last_point_s;
    logic [NCIRC-1:0]        in_s;
    logic [KW-1:0]           n_s;
    logic                    hit_s;

    assign start_s      = (state_r == ST_IDLE) && en;
    assign last_point_s = (x_r == GRID_C) && (y_r == GRID_C);

    // -----------------------------------------------------------------------
    // Stage 1 combinational: per-circle containment test for the current
    // scan point. Differences are taken as magnitudes so centres anywhere in
    // 0..2^CW-1 stay exact; d2 carries one extra bit for the sum.
    // -----------------------------------------------------------------------
    for (genvar i = 0; i < NCIRC; i++) begin : g_circ
        localparam int CB = 2 * CW * (NCIRC - i);
        localparam int RB = CW * (NCIRC - i);

        logic [CW-1:0]   cx_s;
        logic [CW-1:0]   cy_s;
        logic [CW-1:0]   rad_s;
        logic [CW-1:0]   dx_s;
        logic [CW-1:0]   dy_s;
        logic [2*CW:0]   d2_s;
        logic [2*CW-1:0] r2_s;

        assign cx_s  = central_r[CB-1 -: CW];
        assign cy_s  = central_r[CB-CW-1 -: CW];
        assign rad_s = radius_r[RB-1 -: CW];
        assign dx_s  = abs_diff(x_r, cx_s);
        assign dy_s  = abs_diff(y_r, cy_s);
        assign d2_s  = {1'b0, square(dx_s)} + {1'b0, square(dy_s)};
        assign r2_s  = square(rad_s);
        // Boundary counts as inside; radius 0 therefore covers the centre only.
        assign in_s[i] = (d2_s <= {1'b0, r2_s});
    end

    // Stage 2 combinational: reduce the inside bits to one hit per mode.
    always_comb begin
        n_s   = popcount(s1_in_r);
        hit_s = 1'b0;
        case (mode_r)
            2'd0:    hit_s = s1_in_r[0];
            2'd1:    hit_s = &s1_in_r;
            2'd2:    hit_s = n_s[0];
            2'd3:    hit_s = (n_s == k_r);
            default: hit_s = 1'b0;
        endcase
    end

    // Next-state logic for the run sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (en) begin
                    state_s = ST_SCAN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (last_point_s) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_SCAN;
                end
            end
            ST_DRAIN: state_s = ST_DONE;
            ST_DONE:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Run configuration, captured once at the start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            central_r <= '0;
            radius_r  <= '0;
            mode_r    <= 2'd0;
            k_r       <= '0;
        end else if (start_s) begin
            central_r <= central;
            radius_r  <= radius;
            mode_r    <= mode;
            k_r       <= k;
        end
    end

    // Scan coordinate counter: x is the fast axis, wrapping into y.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r <= ONE_C;
            y_r <= ONE_C;
        end else if (start_s) begin
            x_r <= ONE_C;
            y_r <= ONE_C;
        end else if (state_r == ST_SCAN) begin
            if (x_r == GRID_C) begin
                x_r <= ONE_C;
                y_r <= y_r + ONE_C;
            end else begin
                x_r <= x_r + ONE_C;
            end
        end
    end

    // Stage 1 register: inside bits and their valid flag follow the scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_in_r  <= '0;
            s1_vld_r <= 1'b0;
        end else begin
            s1_in_r  <= in_s;
            s1_vld_r <= (state_r == ST_SCAN);
        end
    end

    // Stage 2 accumulator. The last scan point is added on the edge that
    // enters DONE, so candidate is final while valid is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            candidate_r <= '0;
        end else if (start_s) begin
            candidate_r <= '0;
        end else if (s1_vld_r) begin
            candidate_r <= candidate_r + CNTW'(hit_s);
        end
    end

    assign busy      = (state_r != ST_IDLE);
    assign valid     = (state_r == ST_DONE);
    assign candidate = candidate_r;

endmodule
